// File: rtl/access_grant_ctrl_if.sv
// Request/decision bundle for access_grant_ctrl. The requester drives the
// request side (master); the authorization block drives the decision side (slave).
interface access_grant_ctrl_if #(
  parameter int ID_W     = 3,
  parameter int DATA_W   = 8,
  parameter int MAX_FAIL = 3
);
  localparam int FC_W = $clog2(MAX_FAIL + 1);

  logic              req_valid;
  logic              req_ready;
  logic [ID_W-1:0]   usr_id;
  logic [DATA_W-1:0] data_in;
  logic              grant_access;
  logic              data_valid;
  logic [DATA_W-1:0] data_out;
  logic              deny;
  logic              locked;
  logic [FC_W-1:0]   fail_cnt;

  modport master (
    output req_valid, usr_id, data_in,
    input  req_ready, grant_access, data_valid, data_out, deny, locked, fail_cnt
  );

  modport slave (
    input  req_valid, usr_id, data_in,
    output req_ready, grant_access, data_valid, data_out, deny, locked, fail_cnt
  );
endinterface

// File: rtl/access_grant_ctrl.sv
// Authorization stage: grants a captured request only for ALLOWED_ID, releases
// data one edge after capture, and locks out after MAX_FAIL consecutive denials.
module access_grant_ctrl #(
  parameter int              ID_W        = 3,
  parameter int              DATA_W      = 8,
  parameter logic [ID_W-1:0] ALLOWED_ID  = 3'h4,
  parameter int              MAX_FAIL    = 3,
  parameter int              LOCK_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  access_grant_ctrl_if.slave bus
);
  localparam int FC_W  = $clog2(MAX_FAIL + 1);
  localparam int TMR_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [FC_W-1:0]  FAIL_MAX = FC_W'(MAX_FAIL);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(LOCK_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_GRANT, S_DENY, S_LOCK} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [FC_W-1:0]   fail_q, fail_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              ready_q, ready_d;
  logic              grant_q, grant_d;
  logic              deny_q, deny_d;
  logic              locked_q, locked_d;

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    dat_d   = dat_q;
    dout_d  = dout_q;
    fail_d  = fail_q;
    tmr_d   = tmr_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          id_d    = bus.usr_id;
          dat_d   = bus.data_in;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        // Decision is made only on the captured copy, never on live inputs.
        if (id_q == ALLOWED_ID) begin
          state_d = S_GRANT;
          dout_d  = dat_q;
        end else begin
          state_d = S_DENY;
        end
      end
      S_GRANT: begin
        fail_d  = '0;
        state_d = S_IDLE;
      end
      S_DENY: begin
        fail_d = fail_q + 1'b1;
        if (fail_d == FAIL_MAX) begin
          state_d = S_LOCK;
          tmr_d   = TMR_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOCK: begin
        if (tmr_q == '0) begin
          state_d = S_IDLE;
          fail_d  = '0;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered images of the next state, so they line up with it.
    ready_d  = (state_d == S_IDLE);
    grant_d  = (state_d == S_GRANT);
    deny_d   = (state_d == S_DENY);
    locked_d = (state_d == S_LOCK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      id_q     <= '0;
      dat_q    <= '0;
      dout_q   <= '0;
      fail_q   <= '0;
      tmr_q    <= '0;
      ready_q  <= 1'b1;
      grant_q  <= 1'b0;
      deny_q   <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      dat_q    <= dat_d;
      dout_q   <= dout_d;
      fail_q   <= fail_d;
      tmr_q    <= tmr_d;
      ready_q  <= ready_d;
      grant_q  <= grant_d;
      deny_q   <= deny_d;
      locked_q <= locked_d;
    end
  end

  assign bus.req_ready    = ready_q;
  assign bus.grant_access = grant_q;
  assign bus.data_valid   = grant_q;
  assign bus.deny         = deny_q;
  assign bus.locked       = locked_q;
  assign bus.data_out     = dout_q;
  assign bus.fail_cnt     = fail_q;
endmodule
